// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register offsets and CTRL bit positions shared by the timer RTL, software headers and the bench
package apb_timer_pkg;
  localparam logic [6:0] ADDR_CTRL     = 7'h00;
  localparam logic [6:0] ADDR_DIV      = 7'h04;
  localparam logic [6:0] ADDR_TIME     = 7'h08;
  localparam logic [6:0] ADDR_STATUS   = 7'h0C;
  localparam logic [6:0] ADDR_IEN      = 7'h10;
  localparam logic [6:0] ADDR_ARMED    = 7'h14;
  localparam logic [6:0] ADDR_CMP_BASE = 7'h40;
  localparam int CTRL_EN = 0;
endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: down-counting divider producing one tick every div+1 enabled cycles
module apb_timer_prescaler #(
  parameter int W_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             reload,
  input  logic [W_DIV-1:0] div,
  input  logic [W_DIV-1:0] reload_val,
  output logic             tick
);
  logic [W_DIV-1:0] divcnt;
  assign tick = en & (divcnt == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) divcnt <= '0;
    else if (reload) divcnt <= reload_val;
    else if (tick) divcnt <= div;
    else if (en) divcnt <= divcnt - 1'b1;
endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB tick counter with prescaler and one-shot compare channels raising maskable interrupts
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int N_TIMERS = 4,
  parameter int W_DIV    = 8,
  parameter int W_PADDR  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               apbs_psel,
  input  logic               apbs_penable,
  input  logic               apbs_pwrite,
  input  logic [W_PADDR-1:0] apbs_paddr,
  input  logic [31:0]        apbs_pwdata,
  output logic [31:0]        apbs_prdata,
  output logic               apbs_pready,
  output logic               apbs_pslverr,
  output logic [N_TIMERS-1:0] irq
);
  logic en;
  logic [W_DIV-1:0] div;
  logic [31:0] time_q, rdata, cmp_rd;
  logic [31:0] cmp [N_TIMERS];
  logic [N_TIMERS-1:0] status, ien, armed;
  logic [6:0] off;
  logic setup, wr, mapped, is_cmp, tick;
  logic wr_ctrl, wr_div, wr_time, wr_status, wr_ien;
  logic unused_paddr;
  assign unused_paddr = ^{apbs_paddr[W_PADDR-1:7], apbs_paddr[1:0]};
  assign off = {apbs_paddr[6:2], 2'b00};
  assign is_cmp = apbs_paddr[6] & ~apbs_paddr[5] & ({29'b0, apbs_paddr[4:2]} < 32'(N_TIMERS));
  assign setup = apbs_psel & ~apbs_penable;
  assign wr = apbs_psel & apbs_penable & apbs_pwrite & mapped;
  assign wr_ctrl = wr & (off == ADDR_CTRL);
  assign wr_div = wr & (off == ADDR_DIV);
  assign wr_time = wr & (off == ADDR_TIME);
  assign wr_status = wr & (off == ADDR_STATUS);
  assign wr_ien = wr & (off == ADDR_IEN);
  assign apbs_pready = 1'b1;
  assign irq = status & ien;
  always_comb begin
    cmp_rd = '0;
    for (int k = 0; k < N_TIMERS; k++)
      if (apbs_paddr[4:2] == 3'(k)) cmp_rd = cmp[k];
    mapped = 1'b1;
    rdata = '0;
    case (off)
      ADDR_CTRL:   rdata[CTRL_EN] = en;
      ADDR_DIV:    rdata[W_DIV-1:0] = div;
      ADDR_TIME:   rdata = time_q;
      ADDR_STATUS: rdata[N_TIMERS-1:0] = status;
      ADDR_IEN:    rdata[N_TIMERS-1:0] = ien;
      ADDR_ARMED:  rdata[N_TIMERS-1:0] = armed;
      default: begin
        mapped = is_cmp;
        rdata = is_cmp ? cmp_rd : '0;
      end
    endcase
  end
  // any write that touches the time base restarts the prescaler from the (new) DIV value
  apb_timer_prescaler #(.W_DIV(W_DIV)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .reload    (wr_ctrl | wr_div | wr_time),
    .div       (div),
    .reload_val(wr_div ? apbs_pwdata[W_DIV-1:0] : div),
    .tick      (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      apbs_prdata <= '0;
      apbs_pslverr <= 1'b0;
      en <= 1'b0;
      div <= '0;
      ien <= '0;
      time_q <= '0;
    end else begin
      apbs_prdata <= (setup & ~apbs_pwrite & mapped) ? rdata : '0;
      apbs_pslverr <= setup & ~mapped;
      if (wr_ctrl) en <= apbs_pwdata[CTRL_EN];
      if (wr_div) div <= apbs_pwdata[W_DIV-1:0];
      if (wr_ien) ien <= apbs_pwdata[N_TIMERS-1:0];
      time_q <= wr_time ? apbs_pwdata : time_q + 32'(tick);
    end
  for (genvar i = 0; i < N_TIMERS; i++) begin : g_ch
    logic [31:0] cmp_q;
    logic arm_q, st_q, wc, hit;
    assign wc = wr & is_cmp & (apbs_paddr[4:2] == 3'(i));
    assign hit = arm_q & (time_q == cmp_q);
    // a rewrite in the match cycle re-arms instead of firing; a match beats a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cmp_q <= '0;
        arm_q <= 1'b0;
        st_q <= 1'b0;
      end else begin
        if (wc) cmp_q <= apbs_pwdata;
        arm_q <= wc | (arm_q & ~hit);
        st_q <= (hit & ~wc) | (st_q & ~(wr_status & apbs_pwdata[i]));
      end
    assign cmp[i] = cmp_q;
    assign armed[i] = arm_q;
    assign status[i] = st_q;
  end
endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed and random APB traffic checked against a behavioural timer model
module tb_apb_timer;
  import apb_timer_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic [N-1:0] irq;
  int total = 0, bad = 0;
  logic m_en;
  int m_div, m_ph;
  logic [31:0] m_time;
  logic [31:0] m_cmp [N];
  logic [N-1:0] m_armed, m_status, m_ien;
  logic [31:0] exp_rd;
  logic exp_err;
  logic [31:0] rdv, t1;
  logic erv;
  always #5 clk = ~clk;
  apb_timer #(.N_TIMERS(N), .W_DIV(8), .W_PADDR(16)) dut (
    .clk(clk), .rst_n(rst_n), .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
    .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata), .apbs_pready(pready),
    .apbs_pslverr(pslverr), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic mapped(input int idx);
    return idx <= 5 || (idx >= 16 && idx < 16 + N);
  endfunction
  function automatic logic [31:0] rv(input int idx);
    case (idx)
      0: return 32'(m_en);
      1: return 32'(m_div);
      2: return m_time;
      3: return 32'(m_status);
      4: return 32'(m_ien);
      5: return 32'(m_armed);
      default: return (idx >= 16 && idx < 16 + N) ? m_cmp[idx-16] : 32'h0;
    endcase
  endfunction
  // ticks fall on every (div+1)-th enabled cycle counted from the last time-base write
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= 1'b0; m_div <= 0; m_ph <= 0; m_time <= '0;
      m_armed <= '0; m_status <= '0; m_ien <= '0;
      for (int i = 0; i < N; i++) m_cmp[i] <= '0;
      exp_rd <= '0; exp_err <= 1'b0;
    end else begin : step
      int idx;
      logic mp, w, tick, hit;
      logic [N-1:0] clr;
      idx = int'(paddr[6:2]);
      mp = mapped(idx);
      w = psel && penable && pwrite && mp;
      tick = m_en && (m_ph % (m_div + 1) == m_div);
      exp_rd <= (psel && !penable && !pwrite && mp) ? rv(idx) : 32'h0;
      exp_err <= psel && !penable && !mp;
      clr = (w && idx == 3) ? pwdata[N-1:0] : '0;
      for (int i = 0; i < N; i++) begin
        hit = m_armed[i] && m_time == m_cmp[i];
        if (w && idx == 16 + i) begin
          m_cmp[i] <= pwdata;
          m_armed[i] <= 1'b1;
        end else if (hit) begin
          m_armed[i] <= 1'b0;
          m_status[i] <= 1'b1;
        end else if (clr[i]) m_status[i] <= 1'b0;
      end
      m_time <= (w && idx == 2) ? pwdata : m_time + 32'(tick);
      m_ph <= (w && idx <= 2) ? 0 : m_en ? m_ph + 1 : m_ph;
      if (w && idx == 0) m_en <= pwdata[0];
      if (w && idx == 1) m_div <= int'(pwdata[7:0]);
      if (w && idx == 4) m_ien <= pwdata[N-1:0];
    end
  end
  task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    chk("prdata", prdata, exp_rd);
    chk("pslverr", 32'(pslverr), 32'(exp_err));
    chk("irq", 32'(irq), 32'(m_status & m_ien));
    chk("pready", 32'(pready), 32'h1);
    rdv = prdata;
    erv = pslverr;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    xfer(1'b1, a, d);
  endtask
  task automatic rd(input logic [15:0] a);
    xfer(1'b0, a, 32'h0);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask
  initial begin
    int offs [13] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h40, 'h44, 'h48, 'h4C, 'h50, 'h18, 'h7C};
    bit done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_irq", 32'(irq), 32'h0);
    for (int k = 0; k < 10; k++) begin
      rd(16'(offs[k]));
      chk("rst_rd", rdv, 32'h0);
    end
    rd(16'h18);
    chk("unmapped_err", 32'(erv), 32'h1);
    chk("unmapped_rd", rdv, 32'h0);
    idle(1);
    wr(16'(ADDR_DIV), 3); wr(16'(ADDR_TIME), 0); wr(16'(ADDR_CTRL), 1);
    idle(40);
    rd(16'(ADDR_TIME));
    chk("div3_time", rdv, 32'd10);
    wr(16'(ADDR_CTRL), 0);
    rd(16'(ADDR_TIME)); t1 = rdv;
    idle(20);
    rd(16'(ADDR_TIME));
    chk("frozen_time", rdv, t1);
    wr(16'(ADDR_DIV), 0); wr(16'(ADDR_IEN), 1); wr(16'(ADDR_CMP_BASE), 20);
    wr(16'(ADDR_TIME), 0); wr(16'(ADDR_CTRL), 1);
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      rd(16'(ADDR_STATUS));
      done = rdv[0];
    end
    chk("cmp0_fired", 32'(done), 32'h1);
    chk("irq0_up", 32'(irq[0]), 32'h1);
    rd(16'(ADDR_ARMED));
    chk("cmp0_disarmed", 32'(rdv[0]), 32'h0);
    wr(16'(ADDR_STATUS), 1);
    idle(1);
    chk("irq0_down", 32'(irq[0]), 32'h0);
    wr(16'(ADDR_TIME), 0);
    idle(30);
    rd(16'(ADDR_STATUS));
    chk("oneshot", 32'(rdv[0]), 32'h0);
    wr(16'(ADDR_CTRL), 0); wr(16'(ADDR_TIME), 32'hFFFF_FFFE); wr(16'(ADDR_DIV), 0);
    wr(16'(ADDR_CMP_BASE + 4), 1); wr(16'(ADDR_CTRL), 1);
    idle(6);
    rd(16'(ADDR_STATUS));
    chk("wrap_status", rdv, 32'h2);
    rd(16'(ADDR_TIME));
    wr(16'(ADDR_CTRL), 0); wr(16'(ADDR_STATUS), 32'hF); wr(16'(ADDR_CMP_BASE + 8), 100);
    wr(16'(ADDR_CTRL), 1); wr(16'(ADDR_TIME), 99); wr(16'(ADDR_STATUS), 4);
    idle(1);
    rd(16'(ADDR_STATUS));
    chk("w1c_race", 32'(rdv[2]), 32'h1);
    wr(16'(ADDR_CMP_BASE + 8), 200); wr(16'(ADDR_STATUS), 4);
    wr(16'(ADDR_TIME), 199); wr(16'(ADDR_CMP_BASE + 8), 500); wr(16'(ADDR_CTRL), 0);
    rd(16'(ADDR_ARMED));
    chk("rearm_armed", 32'(rdv[2]), 32'h1);
    rd(16'(ADDR_STATUS));
    chk("rearm_status", 32'(rdv[2]), 32'h0);
    wr(16'h50, 32'h1234);
    chk("cmp4_err", 32'(erv), 32'h1);
    for (int k = 0; k < 6; k++) rd(16'(offs[k + 4]));
    idle(1);
    for (int n = 0; n < 400; n++) begin
      int k;
      logic [31:0] d;
      logic [15:0] a;
      k = int'($urandom_range(0, 12));
      a = 16'(offs[k]) | 16'($urandom_range(0, 511) << 7) | 16'($urandom_range(0, 3));
      case (offs[k])
        'h04: d = $urandom_range(0, 3);
        'h08: d = m_time + $urandom_range(0, 40);
        'h40, 'h44, 'h48, 'h4C: d = m_time + $urandom_range(1, 40);
        default: d = $urandom;
      endcase
      xfer(1'($urandom_range(0, 1)), a, d);
      idle(int'($urandom_range(0, 2)));
    end
    wr(16'(ADDR_CTRL), 0); wr(16'(ADDR_IEN), 32'hF); wr(16'(ADDR_CMP_BASE + 12), 7);
    wr(16'(ADDR_TIME), 7);
    idle(3);
    chk("pre_rst_irq3", 32'(irq[3]), 32'h1);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'(ADDR_TIME);
    @(negedge clk);
    penable = 1'b1;
    chk("pre_rst_rd", prdata, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_prdata", prdata, 32'h0);
    chk("async_pslverr", 32'(pslverr), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    rd(16'(ADDR_TIME));
    chk("post_rst_time", rdv, 32'h0);
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
